// File: rtl/uart_tx_ext_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_ext_if
// Purpose  : valid/ready word handshake between a producer and uart_tx_ext.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_ext_if #(
  parameter int BITWIDTH = 8
);
  logic [BITWIDTH-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_ext
// Purpose  : parametrised UART transmitter (5..9 data bits, optional parity,
//            1 or 2 stop bits) with valid/ready input and zero-gap chaining.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ext #(
  parameter int BITWIDTH = 8,
  parameter int DIVISOR  = 16,
  parameter int PARITY   = 0,
  parameter int STOPBITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_ext_if.slave bus,
  output logic         txo,
  output logic         busy
);

  if (BITWIDTH < 5 || BITWIDTH > 9) begin : g_bad_bitwidth
    $error("uart_tx_ext: BITWIDTH must be 5..9");
  end
  if (DIVISOR < 1) begin : g_bad_divisor
    $error("uart_tx_ext: DIVISOR must be >= 1");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_ext: PARITY must be 0, 1 or 2");
  end
  if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stopbits
    $error("uart_tx_ext: STOPBITS must be 1 or 2");
  end

  localparam int              BAUD_W      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(DIVISOR - 1);
  localparam logic [3:0]      C_DATA_LAST = 4'(BITWIDTH - 1);
  localparam logic [3:0]      C_STOP_LAST = 4'(STOPBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                txo_q, txo_d;
  logic                busy_q, busy_d;

  logic w_bit_end;
  logic w_ready;
  logic w_accept;
  logic w_par;

  assign w_bit_end = (baud_q == C_BAUD_LAST);
  // The only non-idle ready cycle is the last clk of the last stop bit.
  assign w_ready   = (state_q == S_IDLE) ||
                     ((state_q == S_STOP) && w_bit_end && (bit_q == C_STOP_LAST));
  assign w_accept  = bus.valid && w_ready;
  assign w_par     = (PARITY == 1) ? ~(^bus.data) : (^bus.data);

  assign bus.ready = w_ready;
  assign txo       = txo_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txo_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txo_q   <= txo_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txo_d   = txo_q;
    busy_d  = busy_q;

    if (state_q != S_IDLE) begin
      baud_d = w_bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        txo_d  = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        bit_d  = '0;
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          txo_d   = shift_q[0];
          bit_d   = '0;
        end
      end
      S_DATA: begin
        // txo always presents shift_q[0]; the next bit is shift_q[1] before the shift lands.
        if (w_bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == C_DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txo_d   = par_q;
            end else begin
              state_d = S_STOP;
              txo_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            txo_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          state_d = S_STOP;
          txo_d   = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (bit_q == C_STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            txo_d   = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txo_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Accept overrides the above; it can only happen in IDLE or the final stop cycle.
    if (w_accept) begin
      state_d = S_START;
      shift_d = bus.data;
      par_d   = w_par;
      txo_d   = 1'b0;
      busy_d  = 1'b1;
      baud_d  = '0;
      bit_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ext
// Purpose  : directed self-checking bench for uart_tx_ext across five configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ext;

  logic       clk;
  logic       rst;
  logic [8:0] data_r [5];
  logic [4:0] valid_r;
  wire  [4:0] txo_w;
  wire  [4:0] busy_w;
  wire  [4:0] ready_w;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inst 0: div4 8N1 | 1: div4 8E1 | 2: div4 8O1 | 3: div2 8N2 | 4: div1 7O1
  uart_tx_ext_if #(.BITWIDTH(8)) if0 ();
  uart_tx_ext_if #(.BITWIDTH(8)) if1 ();
  uart_tx_ext_if #(.BITWIDTH(8)) if2 ();
  uart_tx_ext_if #(.BITWIDTH(8)) if3 ();
  uart_tx_ext_if #(.BITWIDTH(7)) if4 ();

  assign if0.data = data_r[0][7:0]; assign if0.valid = valid_r[0]; assign ready_w[0] = if0.ready;
  assign if1.data = data_r[1][7:0]; assign if1.valid = valid_r[1]; assign ready_w[1] = if1.ready;
  assign if2.data = data_r[2][7:0]; assign if2.valid = valid_r[2]; assign ready_w[2] = if2.ready;
  assign if3.data = data_r[3][7:0]; assign if3.valid = valid_r[3]; assign ready_w[3] = if3.ready;
  assign if4.data = data_r[4][6:0]; assign if4.valid = valid_r[4]; assign ready_w[4] = if4.ready;

  uart_tx_ext #(.BITWIDTH(8), .DIVISOR(4), .PARITY(0), .STOPBITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .txo(txo_w[0]), .busy(busy_w[0]));
  uart_tx_ext #(.BITWIDTH(8), .DIVISOR(4), .PARITY(2), .STOPBITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .txo(txo_w[1]), .busy(busy_w[1]));
  uart_tx_ext #(.BITWIDTH(8), .DIVISOR(4), .PARITY(1), .STOPBITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .txo(txo_w[2]), .busy(busy_w[2]));
  uart_tx_ext #(.BITWIDTH(8), .DIVISOR(2), .PARITY(0), .STOPBITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .txo(txo_w[3]), .busy(busy_w[3]));
  uart_tx_ext #(.BITWIDTH(7), .DIVISOR(1), .PARITY(1), .STOPBITS(1)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave), .txo(txo_w[4]), .busy(busy_w[4]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Present a word for one accept edge, then scramble data to prove it was latched.
  task automatic send(input int inst, input logic [8:0] d);
    @(negedge clk);
    data_r[inst]  = d;
    valid_r[inst] = 1'b1;
    @(posedge clk);
    #1;
    valid_r[inst] = 1'b0;
    data_r[inst]  = ~d;
  endtask

  // pat bit i is the level of frame bit i (start bit at bit 0).
  task automatic run_frame(input int inst, input int div, input int nbits,
                           input logic [31:0] pat, input string tag);
    for (int c = 0; c < div * nbits; c++) begin
      @(negedge clk);
      check({tag, " txo"},   32'(txo_w[inst]),   32'(pat[c / div]));
      check({tag, " ready"}, 32'(ready_w[inst]), 32'(c == div * nbits - 1));
      check({tag, " busy"},  32'(busy_w[inst]),  32'd1);
    end
    @(negedge clk);
    check({tag, " end txo"},   32'(txo_w[inst]),   32'd1);
    check({tag, " end busy"},  32'(busy_w[inst]),  32'd0);
    check({tag, " end ready"}, 32'(ready_w[inst]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] pat;
    rst     = 1'b1;
    valid_r = '0;
    for (int i = 0; i < 5; i++) data_r[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      check("reset txo",   32'(txo_w[i]),   32'd1);
      check("reset busy",  32'(busy_w[i]),  32'd0);
      check("reset ready", 32'(ready_w[i]), 32'd1);
    end

    // 8N1 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    send(0, 9'h0A5);
    run_frame(0, 4, 10, 32'h34A, "8N1 A5");

    // 8E1 0x07 -> parity 1; 8O1 0x07 -> parity 0
    send(1, 9'h007);
    run_frame(1, 4, 11, 32'h60E, "8E1 07");
    send(2, 9'h007);
    run_frame(2, 4, 11, 32'h40E, "8O1 07");

    // 8N2 div2 0xFF -> start then 20 high cycles
    send(3, 9'h0FF);
    run_frame(3, 2, 11, 32'h7FE, "8N2 FF");

    // 7O1 div1 0x03 -> 0,1,1,0,0,0,0,0,1,1
    send(4, 9'h003);
    run_frame(4, 1, 10, 32'h306, "7O1 03");

    // Back-to-back: 0x55 then 0xAA with valid held high across the boundary.
    pat = {12'h0, 10'h354, 10'h2AA};
    @(negedge clk);
    data_r[0]  = 9'h055;
    valid_r[0] = 1'b1;
    @(posedge clk);
    #1;
    data_r[0] = 9'h0AA;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 40) valid_r[0] = 1'b0;
      check("b2b txo",   32'(txo_w[0]),   32'(pat[c / 4]));
      check("b2b busy",  32'(busy_w[0]),  32'd1);
      check("b2b ready", 32'(ready_w[0]), 32'((c % 40) == 39));
    end
    @(negedge clk);
    check("b2b end busy", 32'(busy_w[0]), 32'd0);
    check("b2b end txo",  32'(txo_w[0]),  32'd1);

    // Reset during data bit 3 abandons the frame.
    pat = 32'h34A;
    send(0, 9'h0A5);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("prerst txo", 32'(txo_w[0]), 32'(pat[c / 4]));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst txo",   32'(txo_w[0]),   32'd1);
    check("midrst busy",  32'(busy_w[0]),  32'd0);
    check("midrst ready", 32'(ready_w[0]), 32'd1);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check("postrst txo",  32'(txo_w[0]),  32'd1);
      check("postrst busy", 32'(busy_w[0]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_ext.md
Name: uart_tx_ext

Overview:
Parametrised successor to the 8N1 UART transmitter. It serialises one word per frame with configurable data width, optional odd/even parity and one or two stop bits. It uses a valid/ready handshake and supports zero-gap back-to-back frames. It sits between a byte/word producer (FIFO or command engine) and the serial TX pin, with the baud rate derived from clk by an integer divisor.

Parameters:
bitwidth, 8, data bits per frame; legal range 5..9; out-of-range is an elaboration-time error.
divisor, 16, clk cycles per serial bit; must be >= 1; divisor=1 means one clk per bit.
parity, 0, 0 = none, 1 = odd, 2 = even; any other value is an elaboration-time error.
stopbits, 1, number of stop bits, 1 or 2; any other value is an elaboration-time error.

Ports:
clk  input  1  system clock, baud source
rst  input  1  synchronous reset, active-high
txo  output  1  serial line, idle high, registered
data  input  bitwidth  word to send; sampled only on the accept edge
valid  input  1  producer has a word on data
ready  output  1  block can accept a word this cycle
busy  output  1  frame in progress, registered

Behaviour:
- Reset (rst sampled high at a clk edge): txo=1, busy=0, state=IDLE, counters cleared, ready=1 after that edge. valid is ignored while rst=1.
- Reset mid-frame: the frame is abandoned. txo=1 from the next edge, with no resumption and no partial stop bit.
- Frame length F = 1 + bitwidth + (parity!=0) + stopbits serial bits. The frame occupies divisor*F clk cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txo=1, busy=0, ready=1.
  - On valid&&ready at an edge (the accept edge): capture data into the shift register and compute the parity bit.
    - Odd parity: bit = ~^data (total ones including the parity bit is odd).
    - Even parity: bit = ^data.
  - Also on the accept edge: txo<=0, busy<=1, baud counter<=0, go to START.
- Each state holds txo for exactly divisor clk cycles. The baud counter runs 0..divisor-1 and wraps on the bit-end cycle.
- START -> DATA: data bits are sent LSB first, shifting right. A bit counter counts to bitwidth.
- DATA -> PARITY if parity!=0, else -> STOP.
- PARITY -> STOP.
- STOP: lasts stopbits*divisor cycles with txo=1.
- ready is combinational from state:
  - High in IDLE.
  - Also high during the final clk cycle of the last stop bit. This is the only non-IDLE ready cycle.
  - Low otherwise.
- Accept during the final stop cycle: load new data, txo<=0, stay busy=1, enter START directly. The result is zero idle gap, with start-to-start spacing exactly divisor*F cycles.
- No accept at the end of STOP: go to IDLE; busy<=0 on that edge, and txo stays 1.
- valid while ready=0 is not consumed. The producer must hold valid and data until ready. No internal buffering beyond the single shift register.
- Changes on data after the accept edge have no effect on the current frame.
- Counter widths:
  - Baud counter: max(1, clog2(divisor)) bits.
  - Bit counter: 4 bits.
  - No overflow is possible within the legal parameter ranges.

Test Plan:
- divisor=4, 8N1: send 0xA5 -> txo per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; 40 cycles total; ready low for 39 cycles (high again only in cycle 40); busy low on the edge after cycle 40.
- divisor=4, parity=2 (even): send 0x07 -> parity bit 1. With parity=1 (odd): send 0x07 -> parity bit 0. Frame is 44 cycles; stop bit follows parity.
- divisor=2, stopbits=2, 8 bits: send 0xFF -> start low 2 cycles, then txo high for 20 cycles (16 data + 4 stop); ready high only in the last stop cycle.
- divisor=4, 8N1: valid held high with 0x55 then 0xAA -> second start bit begins exactly 40 cycles after the first; txo never idles between frames; busy stays 1 for 80 cycles.
- divisor=4, 8N1, 0xA5: assert rst for 1 cycle during data bit 3 -> txo=1, busy=0, ready=1 after the edge; no further txo transitions until the next valid.
- divisor=1, bitwidth=7, parity=1 (odd): send 0x03 -> 10-cycle frame 0,1,1,0,0,0,0,0,1,1 (parity bit 1, then stop).
